fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter sharing one ASYNC_FIFO write side among NUM_REQ producers.
//  Lives entirely in the wclk domain, driving the FIFO's winc/wData and observing its wFull/wHalf_full.
//  Grants are burst-locked: a winner keeps the port for up to MAX_BURST words, then the grant rotates.
// PARAMETERS
//  DATA_SIZE  9  width of each producer's data and of wData
//  NUM_REQ    4  number of producers (2..8)
//  MAX_BURST  8  maximum words per grant (1..64)
// PORTS
//  wclk         in   1                   write-domain clock
//  wrst         in   1                   asynchronous active-low reset
//  req_valid    in   NUM_REQ             producer i has a word on req_data[i]
//  req_data     in   NUM_REQ*DATA_SIZE   packed producer data; slice i = [i*DATA_SIZE +: DATA_SIZE]
//  req_ready    out  NUM_REQ             word from producer i is accepted this cycle
//  wFull        in   1                   FIFO full flag (registered in FIFO)
//  wHalf_full   in   1                   FIFO half-full flag
//  winc         out  1                   FIFO write enable
//  wData        out  DATA_SIZE           FIFO write data
//  gnt_id       out  $clog2(NUM_REQ)     index of the current grant holder
//  busy         out  1                   a grant is active (state BURST)
// BEHAVIOUR
//  Reset (wrst low, async): state=IDLE, rr_ptr=0, beat_cnt=0, gnt_id=0; winc=0, req_ready=0, busy=0, wData=0.
//  FSM states are IDLE and BURST; all state, rr_ptr, beat_cnt and gnt_id are registered.
//  IDLE: if |req_valid, the winner is the first set bit searching from rr_ptr upward with wrap.
//    Next cycle: gnt_id=winner, beat_cnt=0, state=BURST. No transfer occurs in IDLE; arbitration costs 1 cycle.
//  BURST transfer condition xfer = req_valid[gnt_id] & ~wFull.
//    Outputs are combinational from registers and inputs: winc=xfer; req_ready[gnt_id]=~wFull; others 0.
//    wData=req_data[gnt_id] (held stable even when winc=0).
//  A producer may only drop req_valid in a cycle where its word was not pending, or after acceptance.
//  BURST exit to IDLE, with rr_ptr <= gnt_id+1 mod NUM_REQ, in any of these cases:
//    (a) xfer and beat_cnt==MAX_BURST-1 -> burst limit reached;
//    (b) !req_valid[gnt_id] -> holder released the grant.
//    wFull alone never ends a burst: the grant is held and winc=0 until space is available.
//  beat_cnt increments on each xfer within BURST. Its width is $clog2(MAX_BURST)+1, so it never wraps within a grant.
//  Fairness: a continuously requesting producer waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles plus full stalls.
//  Reset mid-burst aborts immediately with no partial write: winc drops with reset.
//  req_valid changes by non-holders during BURST are ignored until the next IDLE.
// CONFIGURATION
//  WHALF_THROTTLE_EN defined:
//    In IDLE, while wHalf_full=1, only producer 0 is eligible; other requests are masked.
//    If only others request, the FSM stays IDLE.
//    An active burst by another producer is cut short: exit when wHalf_full=1 at any xfer.
//  WHALF_THROTTLE_EN undefined: wHalf_full is ignored; pure round-robin as above.
// STRUCTURE
//  Package fifo_arb_pkg holds:
//    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
//    localparam helpers for ID width and count width.
//  Sub-module fifo_rr_picker (combinational): inputs req mask and rr_ptr;
//    outputs winner index and any_req. Instantiated once.
//  Top holds the FSM, counters and the output mux.
// TESTING
//  1. Reset with all req_valid=0 -> winc=0, busy=0, req_ready=0, gnt_id=0 for 10 cycles.
//  2. req_valid=4'b0001 with 3 words -> 1 idle cycle, then 3 consecutive winc with req_ready[0]=1, then IDLE, rr_ptr=1.
//  3. All 4 valid continuously, MAX_BURST=8 -> grants 0,1,2,3,0 in turn; exactly 8 winc each, 1 gap cycle per rotation.
//  4. Holder 2 mid-burst, force wFull=1 for 5 cycles -> winc=0 and req_ready[2]=0 for 5 cycles.
//     gnt_id stays 2 and the burst resumes on wFull=0.
//  5. Assert wrst low after beat 3 of a burst -> winc=0 same cycle, state IDLE, rr_ptr=0.
//     After release, arbitration restarts from producer 0.
//  6. WHALF_THROTTLE_EN, wHalf_full=1, req_valid=4'b0110 -> no grant.
//     With req_valid=4'b0111 -> grant 0 only; with wHalf_full=0 -> grant resumes 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;

  localparam int DEF_DATA_SIZE = 9;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int mb);
    return $clog2(mb) + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i, with wrap.
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_req_o
);

  localparam int SW = ID_W + 1;

  logic [NUM_REQ-1:0] rot;
  logic [SW-1:0]      sel;
  logic [SW-1:0]      sum;

  // Rotating the doubled mask puts rr_ptr at bit 0, so the lowest set bit wins.
  assign rot = NUM_REQ'({req_i, req_i} >> rr_ptr_i);

  always_comb begin
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sel = SW'(k);
    end
    sum = {1'b0, rr_ptr_i} + sel;
    if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
    winner_o = sum[ID_W-1:0];
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter for the write side of an async FIFO (wclk domain).
// Optional WHALF_THROTTLE_EN restricts access to producer 0 while the FIFO is half full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                           wclk,
  input  logic                           wrst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wFull,
  input  logic                           wHalf_full,
  output logic                           winc,
  output logic [DATA_SIZE-1:0]           wData,
  output logic [id_width(NUM_REQ)-1:0]   gnt_id,
  output logic                           busy
);

  // state     | meaning
  // ARB_IDLE  | no grant; pick a winner from eligible requests (1 cycle)
  // ARB_BURST | gnt_id_q owns the FIFO port until limit, release or throttle

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    winner;
  logic               any_req;
  logic               holder_valid;
  logic               xfer;
  logic               beat_last;
  logic               throttle_cut;
  logic [ID_W-1:0]    gnt_next_ptr;

`ifdef WHALF_THROTTLE_EN
  assign elig         = wHalf_full ? (req_valid & {{(NUM_REQ-1){1'b0}}, 1'b1}) : req_valid;
  assign throttle_cut = wHalf_full & (gnt_id_q != '0);
`else
  logic unused_whalf;
  assign elig         = req_valid;
  assign throttle_cut = 1'b0;
  assign unused_whalf = wHalf_full;
`endif

  fifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i     (elig),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign busy         = (state_q == ARB_BURST);
  assign holder_valid = req_valid[gnt_id_q];
  assign xfer         = busy & holder_valid & ~wFull;
  assign winc         = xfer;
  assign gnt_id       = gnt_id_q;
  assign beat_last    = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign gnt_next_ptr = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
  assign wData        = busy ? req_data[gnt_id_q*DATA_SIZE +: DATA_SIZE] : '0;

  always_comb begin
    req_ready = '0;
    if (busy && !wFull) req_ready[gnt_id_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          gnt_id_d   = winner;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (!holder_valid) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = gnt_next_ptr;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_last || throttle_cut) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = gnt_next_ptr;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters (4 producers, 9-bit data, burst 8).
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [35:0] req_data;
  logic [3:0]  req_ready;
  logic        wFull;
  logic        wHalf_full;
  logic        winc;
  logic [8:0]  wData;
  logic [1:0]  gnt_id;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(
    .DATA_SIZE (9),
    .NUM_REQ   (4),
    .MAX_BURST (8)
  ) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wFull      (wFull),
    .wHalf_full (wHalf_full),
    .winc       (winc),
    .wData      (wData),
    .gnt_id     (gnt_id),
    .busy       (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".busy"},  36'(busy),      36'd0);
    chk({tag, ".winc"},  36'(winc),      36'd0);
    chk({tag, ".ready"}, 36'(req_ready), 36'd0);
    chk({tag, ".wdata"}, 36'(wData),     36'd0);
  endtask

  task automatic exp_burst(input string tag, input int g, input logic w, input logic [3:0] rdy);
    chk({tag, ".busy"},  36'(busy),      36'd1);
    chk({tag, ".winc"},  36'(winc),      36'(w));
    chk({tag, ".ready"}, 36'(req_ready), 36'(rdy));
    chk({tag, ".gnt"},   36'(gnt_id),    36'(g));
    chk({tag, ".wdata"}, 36'(wData),     36'(9'h0A0 + 9'(g)));
  endtask

  task automatic cyc();
    @(posedge wclk);
    #2;
  endtask

  task automatic do_reset();
    cyc();
    req_valid = 4'b0000;
    wFull = 1'b0;
    wHalf_full = 1'b0;
    wrst = 1'b0;
    cyc();
    wrst = 1'b1;
  endtask

  initial begin
    req_data   = {9'h0A3, 9'h0A2, 9'h0A1, 9'h0A0};
    req_valid  = 4'b0000;
    wFull      = 1'b0;
    wHalf_full = 1'b0;
    wrst       = 1'b1;
    #1 wrst    = 1'b0;

    // 1: reset, no requests
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      exp_idle("t1_rst");
      chk("t1_rst.gnt", 36'(gnt_id), 36'd0);
    end
    cyc();
    wrst = 1'b1;
    #1 exp_idle("t1_rel");

    // 2: producer 0 sends three words
    cyc(); req_valid = 4'b0001; #1 exp_idle("t2_arb");
    for (int i = 0; i < 3; i++) begin
      cyc(); #1 exp_burst("t2_beat", 0, 1'b1, 4'b0001);
    end
    cyc(); req_valid = 4'b0000; #1 exp_burst("t2_rel", 0, 1'b0, 4'b0001);
    cyc(); req_valid = 4'b1111; #1 exp_idle("t2_idle");
    cyc(); req_valid = 4'b0000; #1 exp_burst("t2_rrptr1", 1, 1'b0, 4'b0010);
    cyc(); #1 exp_idle("t2_end");

    // 3: all request continuously -> 0,1,2,3,0 with 8 beats and 1 gap each
    do_reset();
    for (int i = 0; i < 45; i++) begin
      cyc();
      req_valid = 4'b1111;
      #1;
      if (i % 9 == 0) exp_idle("t3_gap");
      else exp_burst("t3_beat", (i / 9) % 4, 1'b1, 4'(1 << ((i / 9) % 4)));
    end
    cyc(); req_valid = 4'b0000; #1 exp_idle("t3_end");

    // 4: holder 2 stalls on wFull for 5 cycles
    do_reset();
    cyc(); req_valid = 4'b0100; #1 exp_idle("t4_arb");
    for (int i = 0; i < 2; i++) begin
      cyc(); #1 exp_burst("t4_pre", 2, 1'b1, 4'b0100);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(); wFull = 1'b1; #1 exp_burst("t4_full", 2, 1'b0, 4'b0000);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(); wFull = 1'b0; #1 exp_burst("t4_post", 2, 1'b1, 4'b0100);
    end

    // 5: rr_ptr is 3 here; reset during producer 3's burst
    cyc(); req_valid = 4'b1111; #1 exp_idle("t4_end");
    for (int i = 0; i < 3; i++) begin
      cyc(); #1 exp_burst("t5_beat", 3, 1'b1, 4'b1000);
    end
    cyc(); wrst = 1'b0; #1;
    exp_idle("t5_rst");
    chk("t5_rst.gnt", 36'(gnt_id), 36'd0);
    cyc(); wrst = 1'b1; #1 exp_idle("t5_rel");
    cyc(); #1 exp_burst("t5_restart", 0, 1'b1, 4'b0001);
    cyc(); req_valid = 4'b0000; #1 exp_burst("t5_drop", 0, 1'b0, 4'b0001);
    cyc(); #1 exp_idle("t5_end");

    // 6: half-full handling
    do_reset();
`ifdef WHALF_THROTTLE_EN
    cyc(); wHalf_full = 1'b1; req_valid = 4'b0110; #1 exp_idle("t6_mask0");
    cyc(); #1 exp_idle("t6_mask1");
    cyc(); req_valid = 4'b0111; #1 exp_idle("t6_mask2");
    cyc(); #1 exp_burst("t6_p0", 0, 1'b1, 4'b0001);
    cyc(); req_valid = 4'b0110; wHalf_full = 1'b0; #1 exp_burst("t6_p0rel", 0, 1'b0, 4'b0001);
    cyc(); #1 exp_idle("t6_idle");
    cyc(); wHalf_full = 1'b1; #1 exp_burst("t6_p1", 1, 1'b1, 4'b0010);
    cyc(); req_valid = 4'b0000; #1 exp_idle("t6_cut");
`else
    cyc(); wHalf_full = 1'b1; req_valid = 4'b0110; #1 exp_idle("t6_arb");
    cyc(); #1 exp_burst("t6_p1", 1, 1'b1, 4'b0010);
    cyc(); #1 exp_burst("t6_p1b", 1, 1'b1, 4'b0010);
    cyc(); req_valid = 4'b0000; #1 exp_burst("t6_rel", 1, 1'b0, 4'b0010);
    cyc(); #1 exp_idle("t6_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
